// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
// Holds the arbiter state enum, the XZR register index and default widths.
package wb_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W_DEF  = 8;

    // X31 reads as zero, so writes to it are swallowed
    localparam logic [4:0] XZR_ADDR = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB0  = 2'd1,
        WB1  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/mux2_1_5bit.sv
// Two-input mux for the register-file address path (width defaults to 5).
module mux2_1_5bit #(
    parameter int W = 5
) (
    input  logic         i_sel,
    input  logic [W-1:0] i_a0,
    input  logic [W-1:0] i_a1,
    output logic [W-1:0] o_y
);

    // Select line 1 picks the second input
    always_comb begin
        o_y = i_sel ? i_a1 : i_a0;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the single register-file write port between
// the ALU/immediate result (req 0) and the load/BL-link result (req 1).
// The winning write is registered for one cycle; writes to XZR are dropped.
// Build option WB_ARB_RR_EN: when defined, contests alternate round-robin;
// when undefined, req 1 always wins a contest and no rr pointer exists.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        req_ready,
    input  logic              wb_stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_sel,
    output logic [CNT_W-1:0]  conflict_cnt
);

    wb_state_e         r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr0;
    logic [ADDR_W-1:0] r_addr1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic [CNT_W-1:0]  r_cnt;

    logic [1:0]        w_ready;
    logic              w_contest;
    logic              w_grant_any;
    logic              w_grant_idx;
    logic [ADDR_W-1:0] w_grant_addr;
    logic              w_is_xzr;

`ifdef WB_ARB_RR_EN
    logic              r_rr_ptr;
`endif

    // Grant decision: nothing while stalled or in reset, at most one ready bit
    always_comb begin
        w_contest = (req_valid == 2'b11);
        w_ready   = 2'b00;
        if (reset && !wb_stall) begin
            case (req_valid)
                2'b01:   w_ready = 2'b01;
                2'b10:   w_ready = 2'b10;
`ifdef WB_ARB_RR_EN
                2'b11:   w_ready = r_rr_ptr ? 2'b10 : 2'b01;
`else
                2'b11:   w_ready = 2'b10;
`endif
                default: w_ready = 2'b00;
            endcase
        end
    end

    assign w_grant_any  = |w_ready;
    assign w_grant_idx  = w_ready[1];
    assign w_grant_addr = w_grant_idx ? req_addr1 : req_addr0;
    assign w_is_xzr     = (w_grant_addr == ADDR_W'(XZR_ADDR));

    // Writeback FSM: next state is the source granted this cycle; captures the write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_wr_en <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_wr_en <= w_grant_any && !w_is_xzr;
            if (!w_grant_any) begin
                r_state <= IDLE;
            end else if (w_grant_idx) begin
                r_state <= WB1;
            end else begin
                r_state <= WB0;
            end
            if (w_ready[0]) begin
                r_addr0 <= req_addr0;
                r_data0 <= req_data0;
            end
            if (w_ready[1]) begin
                r_addr1 <= req_addr1;
                r_data1 <= req_data1;
            end
        end
    end

    // Saturating count of unstalled cycles where both requesters want the port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_contest && !wb_stall && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef WB_ARB_RR_EN
    // After a contested grant the loser becomes preferred for the next contest
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 1'b0;
        end else if (w_contest && w_grant_any) begin
            r_rr_ptr <= ~w_grant_idx;
        end
    end
`endif

    assign req_ready    = w_ready;
    assign wr_en        = r_wr_en;
    assign wr_sel       = (r_state == WB1);
    assign conflict_cnt = r_cnt;

    mux2_1_5bit #(
        .W (ADDR_W)
    ) u_addr_mux (
        .i_sel (wr_sel),
        .i_a0  (r_addr0),
        .i_a1  (r_addr1),
        .o_y   (wr_addr)
    );

    // 64-bit data select follows the same registered select line
    assign wr_data = wr_sel ? r_data1 : r_data0;

endmodule
